// File: rtl/ahb_sram_subordinate_if.sv
// AHB-Lite bus bundle between one initiator and the SRAM subordinate.
// HREADY is the muxed bus ready seen by every subordinate.
interface ahb_sram_subordinate_if #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32
);
  logic                    HSEL;
  logic [AddressWidth-1:0] HADDR;
  logic [1:0]              HTRANS;
  logic                    HWRITE;
  logic [2:0]              HSIZE;
  logic [2:0]              HBURST;
  logic [DataWidth-1:0]    HWDATA;
  logic                    HREADY;
  logic [DataWidth-1:0]    HRDATA;
  logic                    HRESP;
  logic                    HREADYOUT;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE,
    output HSIZE, HBURST, HWDATA, HREADY,
    input  HRDATA, HRESP, HREADYOUT
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE,
    input  HSIZE, HBURST, HWDATA, HREADY,
    output HRDATA, HRESP, HREADYOUT
  );
endinterface

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate over a flop word array with fixed wait states.
// Define AHB_SRAM_SUB_ERR_EN to answer illegal transfers with ERROR.
module ahb_sram_subordinate #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32,
  parameter int DepthWords   = 1024,
  parameter logic [AddressWidth-1:0] BaseAddress = '0,
  parameter int WaitStates   = 0
) (
  input logic HCLK,
  input logic HRESETn,
  ahb_sram_subordinate_if.slave bus
);
  localparam int Bpw    = DataWidth / 8;
  localparam int LogBpw = $clog2(Bpw);
  localparam int IdxW   = $clog2(DepthWords);
  localparam logic [2:0] Ws      = 3'(WaitStates);
  localparam logic [2:0] MaxSize = 3'(LogBpw);

  typedef enum logic [2:0] {
    IDLE, WAIT, DATA, ERR1, ERR2
  } state_t;

  state_t state, state_n;
  logic [2:0]      cnt, cnt_n;
  logic [IdxW-1:0] idx, idx_n;
  logic [Bpw-1:0]  be, be_n;
  logic            wr, wr_n;

  logic                    accept;
  logic                    illegal;
  logic                    ready;
  logic                    resp;
  logic                    commit;
  logic [AddressWidth-1:0] offset;
  logic [AddressWidth-1:0] word;
  logic [LogBpw-1:0]       low;
  logic [2:0]              size_eff;
  logic [Bpw-1:0]          lanes;
  logic                    unused;

  logic [DataWidth-1:0] mem [DepthWords];

  assign accept   = bus.HSEL & bus.HREADY
                  & bus.HTRANS[1];
  assign offset   = bus.HADDR - BaseAddress;
  assign word     = offset >> LogBpw;
  assign low      = bus.HADDR[LogBpw-1:0];
  assign size_eff = (bus.HSIZE > MaxSize)
                  ? MaxSize : bus.HSIZE;
  assign unused   = ^{bus.HBURST, bus.HTRANS[0]};

  // a lane is hit when it shares the beat-sized block of the address
  always_comb begin
    lanes = '0;
    for (int b = 0; b < Bpw; b++)
      lanes[b] = ((LogBpw'(b) ^ low) >> size_eff)
               == '0;
  end

`ifdef AHB_SRAM_SUB_ERR_EN
  localparam logic [AddressWidth-1:0] Limit =
    AddressWidth'(DepthWords * Bpw);

  logic misaligned;

  always_comb begin
    misaligned = 1'b0;
    for (int b = 0; b < LogBpw; b++)
      if (3'(b) < bus.HSIZE && low[b])
        misaligned = 1'b1;
  end

  assign illegal = (offset >= Limit)
                 | (bus.HSIZE > MaxSize)
                 | misaligned;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    be_n    = be;
    wr_n    = wr;
    ready   = 1'b1;
    resp    = 1'b0;
    unique case (state)
      WAIT: begin
        ready = 1'b0;
        if (cnt == 3'd0) state_n = DATA;
        else cnt_n = cnt - 3'd1;
      end
      ERR1: begin
        ready   = 1'b0;
        resp    = 1'b1;
        state_n = ERR2;
      end
      IDLE, DATA, ERR2: begin
        resp = (state == ERR2);
        if (accept) begin
          idx_n = IdxW'(word % AddressWidth'(DepthWords));
          be_n  = lanes;
          wr_n  = bus.HWRITE;
          if (illegal) begin
            state_n = ERR1;
          end else if (Ws != 3'd0) begin
            state_n = WAIT;
            cnt_n   = Ws - 3'd1;
          end else begin
            state_n = DATA;
          end
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      be    <= '0;
      wr    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      be    <= be_n;
      wr    <= wr_n;
    end
  end

  assign commit = (state == DATA) & wr;

  always_ff @(posedge HCLK) begin
    if (commit)
      for (int b = 0; b < Bpw; b++)
        if (be[b])
          mem[idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
  end

  assign bus.HREADYOUT = ready;
  assign bus.HRESP     = resp;
  assign bus.HRDATA    =
    (!wr && (state == WAIT || state == DATA))
    ? mem[idx] : '0;

endmodule
